// File: rtl/riu_histogram.sv
// Dual 10-bin code histogram (RD and NI) accumulated per frame and streamed out as 20 words.
// Define RIU_HIST_SATURATE_EN to make bins saturate at all-ones instead of wrapping.
module riu_histogram #(
  parameter int ROWS      = 30,
  parameter int COLS      = 30,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 done_i,
  input  logic                 progress_done_i,
  input  logic [3:0]           rd_code_i,
  input  logic [3:0]           ni_code_i,
  output logic [CNT_WIDTH-1:0] hist_data_o,
  output logic [4:0]           hist_idx_o,
  output logic                 hist_valid_o,
  output logic                 done_o,
  output logic                 busy_o,
  output logic                 drop_o
);

  localparam int unsigned PIX_MAX = ROWS * COLS;
  localparam int unsigned PIX_W   = $clog2(PIX_MAX + 1);
  localparam int unsigned NBINS   = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_READOUT
  } state_e;

  state_e               state_q, state_d;
  logic [4:0]           idx_q, idx_d;
  logic [PIX_W-1:0]     pix_cnt_q, pix_cnt_d;
  logic [CNT_WIDTH-1:0] rd_bin_q [NBINS];
  logic [CNT_WIDTH-1:0] rd_bin_d [NBINS];
  logic [CNT_WIDTH-1:0] ni_bin_q [NBINS];
  logic [CNT_WIDTH-1:0] ni_bin_d [NBINS];

  logic [CNT_WIDTH-1:0] hist_data_q, hist_data_d;
  logic [4:0]           hist_idx_q, hist_idx_d;
  logic                 hist_valid_q, hist_valid_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 drop_q, drop_d;

  logic [3:0]           rd_sel, ni_sel;
  logic                 accept;

  function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] v);
`ifdef RIU_HIST_SATURATE_EN
    bump = (v == '1) ? v : v + CNT_WIDTH'(1);
`else
    bump = v + CNT_WIDTH'(1);
`endif
  endfunction

  always_comb begin
    state_d      = state_q;
    idx_d        = '0;
    pix_cnt_d    = pix_cnt_q;
    rd_bin_d     = rd_bin_q;
    ni_bin_d     = ni_bin_q;
    hist_data_d  = '0;
    hist_idx_d   = '0;
    hist_valid_d = 1'b0;
    done_d       = 1'b0;
    busy_d       = 1'b0;
    drop_d       = drop_q;

    // Codes 10-15 are folded into the non-uniform bin 9
    rd_sel = (rd_code_i > 4'd9) ? 4'd9 : rd_code_i;
    ni_sel = (ni_code_i > 4'd9) ? 4'd9 : ni_code_i;
    accept = done_i && (state_q != S_READOUT);

    case (state_q)
      S_IDLE: begin
        if (progress_done_i) begin
          state_d = S_READOUT;
        end else if (done_i) begin
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (progress_done_i) begin
          state_d = S_READOUT;
        end
      end
      S_READOUT: begin
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd19) begin
          state_d   = S_IDLE;
          idx_d     = '0;
          pix_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      for (int unsigned i = 0; i < NBINS; i++) begin
        if (rd_sel == 4'(i)) rd_bin_d[i] = bump(rd_bin_q[i]);
        if (ni_sel == 4'(i)) ni_bin_d[i] = bump(ni_bin_q[i]);
      end
      if (pix_cnt_q != PIX_W'(PIX_MAX)) pix_cnt_d = pix_cnt_q + PIX_W'(1);
    end

    if (state_q == S_READOUT) begin
      drop_d       = drop_q | done_i;
      hist_valid_d = 1'b1;
      busy_d       = 1'b1;
      hist_idx_d   = idx_q;
      done_d       = (idx_q == 5'd19);
      // The word leaves on this edge, so its bin is cleared on the same edge
      for (int unsigned i = 0; i < NBINS; i++) begin
        if (idx_q == 5'(i)) begin
          hist_data_d = rd_bin_q[i];
          rd_bin_d[i] = '0;
        end
        if (idx_q == 5'(i + NBINS)) begin
          hist_data_d = ni_bin_q[i];
          ni_bin_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      pix_cnt_q    <= '0;
      rd_bin_q     <= '{default: '0};
      ni_bin_q     <= '{default: '0};
      hist_data_q  <= '0;
      hist_idx_q   <= '0;
      hist_valid_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pix_cnt_q    <= pix_cnt_d;
      rd_bin_q     <= rd_bin_d;
      ni_bin_q     <= ni_bin_d;
      hist_data_q  <= hist_data_d;
      hist_idx_q   <= hist_idx_d;
      hist_valid_q <= hist_valid_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      drop_q       <= drop_d;
    end
  end

  assign hist_data_o  = hist_data_q;
  assign hist_idx_o   = hist_idx_q;
  assign hist_valid_o = hist_valid_q;
  assign done_o       = done_q;
  assign busy_o       = busy_q;
  assign drop_o       = drop_q;

endmodule

// File: tb/tb_riu_histogram.sv
// Directed bench for riu_histogram: frame-level bin model, per-cycle output compare, literal pins.
module tb_riu_histogram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, done_i, progress_done_i;
  logic [3:0]  rd_code_i, ni_code_i;
  logic [15:0] hist_data_o;
  logic [4:0]  hist_idx_o;
  logic        hist_valid_o, done_o, busy_o, drop_o;

  logic        s_rst, s_done, s_prog;
  logic [3:0]  s_rd, s_ni;
  logic [3:0]  s_data;
  logic [4:0]  s_idx;
  logic        s_valid, s_done_o, s_busy, s_drop;

  riu_histogram #(.ROWS(30), .COLS(30), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .done_i(done_i), .progress_done_i(progress_done_i),
    .rd_code_i(rd_code_i), .ni_code_i(ni_code_i), .hist_data_o(hist_data_o),
    .hist_idx_o(hist_idx_o), .hist_valid_o(hist_valid_o), .done_o(done_o),
    .busy_o(busy_o), .drop_o(drop_o)
  );

  riu_histogram #(.ROWS(30), .COLS(30), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(s_rst), .done_i(s_done), .progress_done_i(s_prog),
    .rd_code_i(s_rd), .ni_code_i(s_ni), .hist_data_o(s_data),
    .hist_idx_o(s_idx), .hist_valid_o(s_valid), .done_o(s_done_o),
    .busy_o(s_busy), .drop_o(s_drop)
  );

  typedef struct { int idx; int data; } word_t;

  int    vectors = 0;
  int    errors  = 0;
  bit    chk_en  = 1'b0;
  bit    started = 1'b0;
  word_t exp_q[$];
  int    m_rd[10];
  int    m_ni[10];
  int    got[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int bin_of(input int code);
    return (code > 9) ? 9 : code;
  endfunction

  function automatic int limit_cnt(input int n, input int w);
`ifdef RIU_HIST_SATURATE_EN
    return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
`else
    return n % (1 << w);
`endif
  endfunction

  // Per-cycle comparison of the readout stream against the frame model
  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (hist_valid_o) begin
          check("word_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check("hist_idx", 32'(hist_idx_o), w.idx);
            check("hist_data", 32'(hist_data_o), w.data);
            check("done_o_at_word", 32'(done_o), 32'(w.idx == 19));
            check("busy_in_readout", 32'(busy_o), 1);
            started = (w.idx != 19);
          end
          if (hist_idx_o < 5'd20) got[int'(hist_idx_o)] = int'(hist_data_o);
        end else begin
          check("idle_data", 32'(hist_data_o), 0);
          check("idle_idx", 32'(hist_idx_o), 0);
          check("idle_done", 32'(done_o), 0);
          check("idle_busy", 32'(busy_o), 0);
          check("readout_gap", 32'(started), 0);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input int rc, input int nc);
    done_i    = 1'b1;
    rd_code_i = 4'(rc);
    ni_code_i = 4'(nc);
    m_rd[bin_of(rc)]++;
    m_ni[bin_of(nc)]++;
    tick();
    done_i = 1'b0;
  endtask

  task automatic wait_readout;
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check("readout_complete", 32'(exp_q.size()), 0);
    check("post_readout_idle", 32'(hist_valid_o), 0);
  endtask

  task automatic end_frame(input bit with_px, input int rc, input int nc, input bit wait_done);
    progress_done_i = 1'b1;
    if (with_px) begin
      done_i    = 1'b1;
      rd_code_i = 4'(rc);
      ni_code_i = 4'(nc);
      m_rd[bin_of(rc)]++;
      m_ni[bin_of(nc)]++;
    end
    for (int i = 0; i < 10; i++) exp_q.push_back('{i, limit_cnt(m_rd[i], 16)});
    for (int i = 0; i < 10; i++) exp_q.push_back('{i + 10, limit_cnt(m_ni[i], 16)});
    for (int i = 0; i < 10; i++) begin m_rd[i] = 0; m_ni[i] = 0; end
    for (int i = 0; i < 20; i++) got[i] = -1;
    tick();
    progress_done_i = 1'b0;
    done_i          = 1'b0;
    check("readout_latency", 32'(hist_valid_o), 0);
    if (wait_done) wait_readout();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, v1, v11, others, done_at, expect4;
    bit found;
    rst = 1'b1; done_i = 1'b0; progress_done_i = 1'b0; rd_code_i = '0; ni_code_i = '0;
    s_rst = 1'b1; s_done = 1'b0; s_prog = 1'b0; s_rd = '0; s_ni = '0;
    for (int i = 0; i < 10; i++) begin m_rd[i] = 0; m_ni[i] = 0; end
    tick();
    tick();
    check("rst_valid", 32'(hist_valid_o), 0);
    check("rst_data", 32'(hist_data_o), 0);
    check("rst_idx", 32'(hist_idx_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_drop", 32'(drop_o), 0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Full frame of one code pair
    for (int i = 0; i < 900; i++) pixel(3, 7);
    end_frame(1'b0, 0, 0, 1'b1);
    check("full_idx3", got[3], 900);
    check("full_idx17", got[17], 900);
    others = 0;
    for (int i = 0; i < 20; i++) if (i != 3 && i != 17) others += got[i];
    check("full_others_zero", others, 0);

    // Out-of-range codes land in bin 9
    for (int i = 0; i < 5; i++) pixel(12, 15);
    end_frame(1'b0, 0, 0, 1'b1);
    check("nonuni_idx9", got[9], 5);
    check("nonuni_idx19", got[19], 5);

    // Every code once on each histogram
    for (int i = 0; i < 16; i++) pixel(i, 15 - i);
    end_frame(1'b0, 0, 0, 1'b1);
    check("sweep_idx0", got[0], 1);
    check("sweep_idx9", got[9], 7);
    check("sweep_idx19", got[19], 7);

    // Single pixel coincident with end of frame, from IDLE
    end_frame(1'b1, 0, 0, 1'b1);
    check("coinc_idx0", got[0], 1);
    check("coinc_idx10", got[10], 1);

    // Empty frame
    end_frame(1'b0, 0, 0, 1'b1);
    others = 0;
    for (int i = 0; i < 20; i++) others += got[i];
    check("empty_frame_sum", others, 0);

    // Pixels and a stray end-of-frame during readout are ignored
    check("drop_before", 32'(drop_o), 0);
    for (int i = 0; i < 3; i++) pixel(2, 5);
    end_frame(1'b0, 0, 0, 1'b0);
    done_i = 1'b1; rd_code_i = 4'd2; ni_code_i = 4'd5;
    tick();
    progress_done_i = 1'b1;
    tick();
    progress_done_i = 1'b0;
    tick();
    done_i = 1'b0;
    wait_readout();
    check("drop_idx2", got[2], 3);
    check("drop_idx15", got[15], 3);
    check("drop_sticky", 32'(drop_o), 1);
    pixel(4, 4);
    end_frame(1'b0, 0, 0, 1'b1);
    check("after_drop_idx4", got[4], 1);
    check("after_drop_idx2", got[2], 0);
    check("drop_still_set", 32'(drop_o), 1);

    // Reset while word 5 is on the outputs
    for (int i = 0; i < 4; i++) pixel(6, 8);
    end_frame(1'b0, 0, 0, 1'b0);
    found = 1'b0;
    n = 0;
    while (!found && n < 30) begin
      @(negedge clk);
      #1;
      found = hist_valid_o && (hist_idx_o == 5'd5);
      n++;
    end
    check("reached_idx5", 32'(found), 1);
    rst = 1'b1;
    exp_q.delete();
    started = 1'b0;
    tick();
    check("abort_valid", 32'(hist_valid_o), 0);
    check("abort_done", 32'(done_o), 0);
    check("abort_drop_cleared", 32'(drop_o), 0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) pixel(1, 2);
    end_frame(1'b0, 0, 0, 1'b1);
    check("post_abort_idx1", got[1], 2);
    check("post_abort_idx12", got[12], 2);
    check("post_abort_idx6", got[6], 0);
    check("post_abort_idx18", got[18], 0);

    // Narrow counters: 20 hits into a 4-bit bin
`ifdef RIU_HIST_SATURATE_EN
    expect4 = 15;
`else
    expect4 = 4;
`endif
    s_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_done = 1'b1; s_rd = 4'd1; s_ni = 4'd1;
      tick();
    end
    s_done = 1'b0;
    s_prog = 1'b1;
    tick();
    s_prog = 1'b0;
    v1 = -1; v11 = -1; others = 0; done_at = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (s_valid) begin
        if (s_idx == 5'd1) v1 = int'(s_data);
        else if (s_idx == 5'd11) v11 = int'(s_data);
        else others += int'(s_data);
        if (s_done_o) done_at = int'(s_idx);
      end
    end
    check("narrow_idx1", v1, expect4);
    check("narrow_idx11", v11, expect4);
    check("narrow_others", others, 0);
    check("narrow_done_idx", done_at, 19);
    check("narrow_idle_after", 32'(s_busy), 0);
    check("narrow_drop", 32'(s_drop), 0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
